round_sequencer: RTL

- Top-level game controller that sequences one Whack-A-Mole round around the existing gameplay datapath (level, hit position in, score and mole position out).
- Latches the level on start, runs a countdown, then a timed play window, and emits mole-spawn pulses whose rate depends on the level.
- Freezes the final score, tracks the session high score and reports game-over to the display logic.

---
 rtl/game_pkg.sv | 23 ++
 rtl/tick_gen.sv | 49 ++++
 rtl/round_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the Whack-A-Mole round controller and gameplay datapath.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_OVER      = 2'd3
    } game_state_e;

    localparam int LEVEL_W = 2;
    localparam int SCORE_W = 6;
    localparam int POS_W   = 3;
    localparam int TIME_W  = 6;
    localparam int CD_W    = 2;

    // Mole spawn period in ticks: each level halves the interval.
    function automatic int unsigned spawn_period(input int unsigned tps,
                                                 input logic [LEVEL_W-1:0] lvl);
        return tps >> lvl;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Game timebase: prescaler producing a tick every TICK_CYCLES clocks and a
// second pulse every TICKS_PER_SEC ticks; clear restarts both from zero.
module tick_gen #(
    parameter int TICK_CYCLES   = 100000,
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic sec_pulse
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] SEC_LAST = SW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] sec_q, sec_d;

    assign tick      = (pre_q == PRE_LAST);
    assign sec_pulse = tick && (sec_q == SEC_LAST);

    always_comb begin
        pre_d = pre_q;
        sec_d = sec_q;
        if (clear) begin
            pre_d = '0;
            sec_d = '0;
        end else if (tick) begin
            pre_d = '0;
            sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
            sec_q <= '0;
        end else begin
            pre_q <= pre_d;
            sec_q <= sec_d;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Round controller: latches level, runs countdown and timed play window,
// schedules mole spawns, freezes the final score and tracks the high score.
//
//   state        | meaning
//   ST_IDLE      | waiting for the first start after reset
//   ST_COUNTDOWN | pre-round countdown, countdown shows seconds left
//   ST_PLAY      | play window open, hits accepted, spawns scheduled
//   ST_OVER      | round finished, results held until restart
module round_sequencer
    import game_pkg::*;
#(
    parameter int TICK_CYCLES   = 100000,
    parameter int TICKS_PER_SEC = 1000,
    parameter int ROUND_SEC     = 30,
    parameter int COUNTDOWN_SEC = 3
) (
    input  logic               CLK100MHZ,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEVEL_W-1:0] levl,
    input  logic [SCORE_W-1:0] score,
    output logic               play_en,
    output logic               spawn,
    output logic [LEVEL_W-1:0] level_lat,
    output logic [1:0]         state,
    output logic [CD_W-1:0]    countdown,
    output logic [TIME_W-1:0]  time_left,
    output logic [SCORE_W-1:0] final_score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high
);

    localparam int SPW = $clog2(TICKS_PER_SEC);
    localparam logic [CD_W-1:0]   CD_INIT   = CD_W'(COUNTDOWN_SEC);
    localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(ROUND_SEC);

    game_state_e        state_q, state_d;
    logic               play_en_q, play_en_d;
    logic               spawn_q, spawn_d;
    logic [LEVEL_W-1:0] level_lat_q, level_lat_d;
    logic [CD_W-1:0]    countdown_q, countdown_d;
    logic [TIME_W-1:0]  time_left_q, time_left_d;
    logic [SCORE_W-1:0] final_score_q, final_score_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic               new_high_q, new_high_d;
    logic [SPW-1:0]     spawn_cnt_q, spawn_cnt_d;

    logic               tick;
    logic               sec_pulse;
    logic               tick_clear;
    logic [SPW-1:0]     spawn_last;

    // Restarting the timebase on every state change keeps each state's
    // duration an exact number of ticks.
    assign tick_clear = (state_d != state_q);

    tick_gen #(
        .TICK_CYCLES   (TICK_CYCLES),
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_tick_gen (
        .clk       (CLK100MHZ),
        .rst_n     (rst_n),
        .clear     (tick_clear),
        .tick      (tick),
        .sec_pulse (sec_pulse)
    );

    assign spawn_last = SPW'(spawn_period(TICKS_PER_SEC, level_lat_q) - 1);

    always_comb begin
        state_d       = state_q;
        play_en_d     = play_en_q;
        spawn_d       = 1'b0;
        level_lat_d   = level_lat_q;
        countdown_d   = countdown_q;
        time_left_d   = time_left_q;
        final_score_d = final_score_q;
        high_score_d  = high_score_q;
        new_high_d    = new_high_q;
        spawn_cnt_d   = spawn_cnt_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_COUNTDOWN;
                    level_lat_d = levl;
                    countdown_d = CD_INIT;
                    new_high_d  = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (sec_pulse) begin
                    if (countdown_q <= CD_W'(1)) begin
                        state_d     = ST_PLAY;
                        countdown_d = '0;
                        time_left_d = TIME_INIT;
                        play_en_d   = 1'b1;
                        spawn_d     = 1'b1;
                        spawn_cnt_d = '0;
                    end else begin
                        countdown_d = countdown_q - 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (sec_pulse && (time_left_q <= TIME_W'(1))) begin
                    state_d       = ST_OVER;
                    time_left_d   = '0;
                    play_en_d     = 1'b0;
                    final_score_d = score;
                    if (score > high_score_q) begin
                        high_score_d = score;
                        new_high_d   = 1'b1;
                    end
                end else begin
                    if (sec_pulse) begin
                        time_left_d = time_left_q - 1'b1;
                    end
                    if (tick) begin
                        if (spawn_cnt_q == spawn_last) begin
                            spawn_d     = 1'b1;
                            spawn_cnt_d = '0;
                        end else begin
                            spawn_cnt_d = spawn_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            play_en_q     <= 1'b0;
            spawn_q       <= 1'b0;
            level_lat_q   <= '0;
            countdown_q   <= '0;
            time_left_q   <= '0;
            final_score_q <= '0;
            high_score_q  <= '0;
            new_high_q    <= 1'b0;
            spawn_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            play_en_q     <= play_en_d;
            spawn_q       <= spawn_d;
            level_lat_q   <= level_lat_d;
            countdown_q   <= countdown_d;
            time_left_q   <= time_left_d;
            final_score_q <= final_score_d;
            high_score_q  <= high_score_d;
            new_high_q    <= new_high_d;
            spawn_cnt_q   <= spawn_cnt_d;
        end
    end

    assign state       = state_q;
    assign play_en     = play_en_q;
    assign spawn       = spawn_q;
    assign level_lat   = level_lat_q;
    assign countdown   = countdown_q;
    assign time_left   = time_left_q;
    assign final_score = final_score_q;
    assign high_score  = high_score_q;
    assign new_high    = new_high_q;

endmodule
